fdct4_serial: RTL and testbench



---
 rtl/dct_pkg.sv | 27 ++
 rtl/fdct4_butterfly.sv | 20 ++
 rtl/fdct4_serial.sv | 117 +++++++++++
 tb/tb_fdct4_serial.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared definitions for the 4-point DCT/IDCT datapaths: kernel constants,
// default widths, the serial FSM state type and the round-and-shift helper.
package dct_pkg;

  localparam int C64 = 64;
  localparam int C83 = 83;
  localparam int C36 = 36;

  localparam int unsigned DefDinW  = 16;
  localparam int unsigned DefDoutW = 25;

  typedef enum logic [1:0] {
    StLoad,
    StCalc,
    StSend
  } fdct_state_e;

  // Round half up, then arithmetic shift (floor toward -inf). Callers size the result.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] y,
                                                     input int unsigned      shift);
    logic signed [63:0] add;
    add = '0;
    if (shift > 0) add = 64'sd1 <<< (shift - 1);
    return (y + add) >>> shift;
  endfunction

endpackage

// File: rtl/fdct4_butterfly.sv
// Even/odd butterfly for the 4-point forward DCT; one bit of growth on each output.
module fdct4_butterfly #(
  parameter int unsigned DIN_W = 16
) (
  input  logic signed [DIN_W-1:0] x0_i,
  input  logic signed [DIN_W-1:0] x1_i,
  input  logic signed [DIN_W-1:0] x2_i,
  input  logic signed [DIN_W-1:0] x3_i,
  output logic signed [DIN_W:0]   e0_o,
  output logic signed [DIN_W:0]   e1_o,
  output logic signed [DIN_W:0]   o0_o,
  output logic signed [DIN_W:0]   o1_o
);

  assign e0_o = (DIN_W + 1)'(x0_i) + (DIN_W + 1)'(x3_i);
  assign e1_o = (DIN_W + 1)'(x1_i) + (DIN_W + 1)'(x2_i);
  assign o0_o = (DIN_W + 1)'(x0_i) - (DIN_W + 1)'(x3_i);
  assign o1_o = (DIN_W + 1)'(x1_i) - (DIN_W + 1)'(x2_i);

endmodule

// File: rtl/fdct4_serial.sv
// Serial-in/serial-out 4-point forward integer DCT (64/83/36 kernel) with
// valid/ready on both sides: LOAD four samples, CALC one cycle, SEND four coefficients.
module fdct4_serial
  import dct_pkg::*;
#(
  parameter int unsigned DIN_W  = DefDinW,
  parameter int unsigned DOUT_W = DefDoutW,
  parameter int unsigned SHIFT  = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DIN_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DOUT_W-1:0] out_data,
  output logic [1:0]               out_idx,
  output logic                     out_last
);

  localparam int unsigned IW = DIN_W + 11;

  localparam logic signed [IW-1:0] K64 = IW'(C64);
  localparam logic signed [IW-1:0] K83 = IW'(C83);
  localparam logic signed [IW-1:0] K36 = IW'(C36);

  fdct_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;

  logic signed [DIN_W-1:0]  x_q   [4];
  logic signed [DIN_W-1:0]  x_d   [4];
  logic signed [DOUT_W-1:0] res_q [4];
  logic signed [DOUT_W-1:0] res_d [4];

  logic signed [DIN_W:0] e0, e1, o0, o1;
  logic signed [IW-1:0]  y_w [4];

  fdct4_butterfly #(
    .DIN_W(DIN_W)
  ) u_butterfly (
    .x0_i(x_q[0]),
    .x1_i(x_q[1]),
    .x2_i(x_q[2]),
    .x3_i(x_q[3]),
    .e0_o(e0),
    .e1_o(e1),
    .o0_o(o0),
    .o1_o(o1)
  );

  assign y_w[0] = K64 * (IW'(e0) + IW'(e1));
  assign y_w[1] = K83 * IW'(o0) + K36 * IW'(o1);
  assign y_w[2] = K64 * (IW'(e0) - IW'(e1));
  assign y_w[3] = K36 * IW'(o0) - K83 * IW'(o1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    x_d       = x_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d[cnt_q] = in_data;
          cnt_d      = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StCalc;
        end
      end
      StCalc: begin
        // Results are truncated to DOUT_W; the kernel gain keeps them in range.
        for (int k = 0; k < 4; k++) begin
          res_d[k] = DOUT_W'(round_shift(64'(y_w[k]), SHIFT));
        end
        idx_d   = 2'd0;
        state_d = StSend;
      end
      StSend: begin
        out_valid = 1'b1;
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign out_data = (state_q == StSend) ? res_q[idx_q] : '0;
  assign out_idx  = idx_q;
  assign out_last = (state_q == StSend) && (idx_q == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        x_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_fdct4_serial.sv
// Self-checking bench for fdct4_serial: one instance at SHIFT=0 (index 0) and one at
// SHIFT=7 (index 1), table vectors, hand-written corner sequences and random blocks.
module tb_fdct4_serial;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]       in_valid, in_ready, out_valid, out_ready, out_last;
  logic [1:0][15:0] in_data;
  logic [1:0][24:0] out_data;
  logic [1:0][1:0]  out_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fdct4_serial #(.DIN_W(16), .DOUT_W(25), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_idx(out_idx[0]), .out_last(out_last[0])
  );

  fdct4_serial #(.DIN_W(16), .DOUT_W(25), .SHIFT(7)) u_dut7 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_idx(out_idx[1]), .out_last(out_last[1])
  );

  typedef struct {
    int sel;
    int x [4];
    int y [4];
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: direct DCT sums, then floor((y + half) / 2^shift) via integer division.
  function automatic longint ref_coef(input int x [4], input int k, input int sh);
    longint y, add, d, v, q;
    case (k)
      0: y = 64 * (longint'(x[0]) + x[1] + x[2] + x[3]);
      1: y = 83 * (longint'(x[0]) - x[3]) + 36 * (longint'(x[1]) - x[2]);
      2: y = 64 * ((longint'(x[0]) + x[3]) - (longint'(x[1]) + x[2]));
      default: y = 36 * (longint'(x[0]) - x[3]) - 83 * (longint'(x[1]) - x[2]);
    endcase
    add = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
    d   = longint'(1) << sh;
    v   = y + add;
    q   = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  task automatic push(input int sel, input int val, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    in_valid[sel] = 1'b1;
    in_data[sel]  = 16'(val);
    n = 0;
    while (!in_ready[sel] && n < 40) begin @(posedge clk); #1; n++; end
    if (!in_ready[sel]) chk("in_ready timeout", 0, 1);
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
  endtask

  task automatic send_block(input int sel, input int x [4], input bit gaps);
    for (int i = 0; i < 4; i++) push(sel, x[i], gaps);
  endtask

  task automatic recv_block(input int sel, input longint exp [4], input bit bp, input string tag);
    int n;
    out_ready[sel] = !bp;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!out_valid[sel] && n < 40) begin @(posedge clk); #1; n++; end
      chk({tag, " out_valid"}, out_valid[sel], 1);
      if (i > 0 && !bp) chk({tag, " back-to-back"}, n, 0);
      if (bp) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
          chk({tag, " held data"}, $signed(out_data[sel]), exp[i]);
        end
        out_ready[sel] = 1'b1;
      end
      chk({tag, " data"}, $signed(out_data[sel]), exp[i]);
      chk({tag, " idx"}, out_idx[sel], i);
      chk({tag, " last"}, out_last[sel], (i == 3) ? 1 : 0);
      @(posedge clk); #1;
      if (bp) out_ready[sel] = 1'b0;
    end
    out_ready[sel] = 1'b0;
    chk({tag, " valid drops"}, out_valid[sel], 0);
    chk({tag, " in_ready back"}, in_ready[sel], 1);
  endtask

  task automatic check_reset_outputs(input int sel);
    chk("rst in_ready", in_ready[sel], 1);
    chk("rst out_valid", out_valid[sel], 0);
    chk("rst out_data", out_data[sel], 0);
    chk("rst out_idx", out_idx[sel], 0);
    chk("rst out_last", out_last[sel], 0);
  endtask

  initial begin
    int     x [4];
    longint e [4];

    tv[0] = '{sel: 1, x: '{100, 100, 100, 100}, y: '{200, 0, 0, 0}};
    tv[1] = '{sel: 0, x: '{1, 0, 0, 0}, y: '{64, 83, 64, 36}};
    tv[2] = '{sel: 0, x: '{-1, 0, 0, 0}, y: '{-64, -83, -64, -36}};
    tv[3] = '{sel: 1, x: '{1, 0, 0, 0}, y: '{1, 1, 1, 0}};
    tv[4] = '{sel: 1, x: '{-1, 0, 0, 0}, y: '{0, -1, 0, 0}};
    tv[5] = '{sel: 0, x: '{-32768, -32768, -32768, -32768}, y: '{-8388608, 0, 0, 0}};
    tv[6] = '{sel: 0, x: '{0, 1, 0, 0}, y: '{64, 36, -64, -83}};

    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    reset     = 1'b0;
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Latency: CALC cycle right after x3, then valid one edge later.
    x = tv[0].x;
    send_block(1, x, 1'b0);
    chk("lat calc out_valid", out_valid[1], 0);
    chk("lat calc in_ready", in_ready[1], 0);
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("lat out_valid", out_valid[1], 1);
    for (int k = 0; k < 4; k++) e[k] = tv[0].y[k];
    recv_block(1, e, 1'b0, "lat");

    for (int t = 1; t < 7; t++) begin
      x = tv[t].x;
      for (int k = 0; k < 4; k++) e[k] = tv[t].y[k];
      send_block(tv[t].sel, x, 1'b0);
      recv_block(tv[t].sel, e, 1'b0, $sformatf("vec%0d", t));
    end

    // Backpressure at idx 1 with ignored input pulses.
    x = '{5, -3, 7, 2};
    for (int k = 0; k < 4; k++) e[k] = ref_coef(x, k, 0);
    send_block(0, x, 1'b0);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp beat0 idx", out_idx[0], 0);
    chk("bp beat0 data", $signed(out_data[0]), e[0]);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = c[0] ? 1'b0 : 1'b1;
      in_data[0]  = 16'h1234;
      @(posedge clk); #1;
      chk("bp hold valid", out_valid[0], 1);
      chk("bp hold idx", out_idx[0], 1);
      chk("bp hold data", $signed(out_data[0]), e[1]);
      chk("bp in_ready", in_ready[0], 0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("bp rel idx", out_idx[0], i);
      chk("bp rel data", $signed(out_data[0]), e[i]);
      chk("bp rel last", out_last[0], (i == 3) ? 1 : 0);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b0;
    chk("bp in_ready back", in_ready[0], 1);
    x = '{1, 0, 0, 0};
    e = '{64, 83, 64, 36};
    send_block(0, x, 1'b0);
    recv_block(0, e, 1'b0, "after bp");

    // Reset mid-block discards the partial samples.
    push(0, 7, 1'b0);
    push(0, 9, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs(0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    x = '{1, 0, 0, 0};
    send_block(0, x, 1'b0);
    recv_block(0, e, 1'b0, "after rst");

    // Random blocks against the reference model.
    for (int b = 0; b < 30; b++) begin
      int sel;
      sel = $urandom_range(0, 1);
      for (int k = 0; k < 4; k++) x[k] = int'($urandom_range(0, 65535)) - 32768;
      for (int k = 0; k < 4; k++) e[k] = ref_coef(x, k, (sel == 1) ? 7 : 0);
      send_block(sel, x, 1'b1);
      recv_block(sel, e, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
